// File: rtl/tlb_entry_reader.sv
// tlb_entry_reader
//   Fully-associative translation cache with a single-stage registered lookup
//   response and a refill port. Entries hold {valid, vpn tag, 32-bit data},
//   where data packs {ppn[19:0], u, ae, sw, sx, sr, pw, px, pr, pal, paa, eff, c}
//   with ppn at bits 31:12 and c at bit 0.
//
//   Optional feature macro: TLB_HIT_COUNT_EN adds a 16-bit saturating hit
//   counter output (io_hit_count), cleared by io_flush.
//
// Ports
//   clock, reset_n               : clock, asynchronous active-low reset
//   io_refill_valid/_vpn/_data   : write one entry this cycle
//   io_flush                     : invalidate every entry at the next edge
//   io_req_valid/_ready/_vpn     : lookup request handshake
//   io_resp_valid/_ready         : lookup response handshake
//   io_resp_hit, io_resp_ppn,
//   io_resp_u .. io_resp_c       : registered lookup result (zero on miss)
//   io_hit_count                 : (TLB_HIT_COUNT_EN only) accepted hits
`timescale 1ns/1ps

module tlb_entry_reader #(
  parameter int ENTRIES  = 8,
  parameter int VPN_BITS = 27
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                io_refill_valid,
  input  logic [VPN_BITS-1:0] io_refill_vpn,
  input  logic [31:0]         io_refill_data,
  input  logic                io_flush,
  input  logic                io_req_valid,
  output logic                io_req_ready,
  input  logic [VPN_BITS-1:0] io_req_vpn,
  output logic                io_resp_valid,
  input  logic                io_resp_ready,
  output logic                io_resp_hit,
  output logic [19:0]         io_resp_ppn,
  output logic                io_resp_u,
  output logic                io_resp_ae,
  output logic                io_resp_sw,
  output logic                io_resp_sx,
  output logic                io_resp_sr,
  output logic                io_resp_pw,
  output logic                io_resp_px,
  output logic                io_resp_pr,
  output logic                io_resp_pal,
  output logic                io_resp_paa,
  output logic                io_resp_eff,
`ifdef TLB_HIT_COUNT_EN
  output logic [15:0]         io_hit_count,
`endif
  output logic                io_resp_c
);

  localparam int IDX_BITS = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(ENTRIES - 1);

  // Entry storage. Tags and data are compared in parallel, so they live in
  // flops; only the valid bits need a reset.
  logic [ENTRIES-1:0]  valid_reg;
  logic [VPN_BITS-1:0] tag_mem [ENTRIES];
  logic [31:0]         data_mem [ENTRIES];
  logic [IDX_BITS-1:0] victim_reg;

  // Response register
  logic        resp_valid_reg;
  logic        resp_hit_reg;
  logic [31:0] resp_data_reg;

  logic [ENTRIES-1:0]  lookup_match;
  logic [ENTRIES-1:0]  refill_match;
  logic                lookup_hit;
  logic [31:0]         lookup_data;
  logic                req_fire;
  logic                refill_fire;
  logic                free_found;
  logic [IDX_BITS-1:0] free_idx;
  logic                match_found;
  logic [IDX_BITS-1:0] match_idx;
  logic [IDX_BITS-1:0] refill_slot;
  logic                refill_evicts;
  logic [IDX_BITS-1:0] victim_next;

  assign io_req_ready = !resp_valid_reg || io_resp_ready;
  assign req_fire     = io_req_valid && io_req_ready;
  // A flush in the same cycle drops the refill.
  assign refill_fire  = io_refill_valid && !io_flush;

  // Parallel tag compare for lookup and refill.
  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_cmp
      assign lookup_match[gi] = valid_reg[gi] && (tag_mem[gi] == io_req_vpn);
      assign refill_match[gi] = valid_reg[gi] && (tag_mem[gi] == io_refill_vpn);
    end
  endgenerate

  // Tags are unique among valid entries, so at most one bit of lookup_match
  // is set and an OR of masked data is a correct one-hot mux. The lookup reads
  // the current array, so a same-cycle refill is not visible to it.
  always_comb begin
    lookup_data = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (lookup_match[i]) begin
        lookup_data = lookup_data | data_mem[i];
      end
    end
  end
  assign lookup_hit = |lookup_match;

  // Refill slot: existing matching tag, else lowest free entry, else victim.
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    match_found = 1'b0;
    match_idx   = '0;
    // Scan downward so the last assignment wins with the lowest index.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_reg[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_BITS'(i);
      end
      if (refill_match[i]) begin
        match_found = 1'b1;
        match_idx   = IDX_BITS'(i);
      end
    end
    refill_slot   = victim_reg;
    refill_evicts = 1'b0;
    if (match_found) begin
      refill_slot = match_idx;
    end else if (free_found) begin
      refill_slot = free_idx;
    end else begin
      refill_evicts = 1'b1;
    end
  end

  // The victim pointer only moves when a valid, unrelated entry is displaced.
  always_comb begin
    victim_next = victim_reg;
    if (refill_fire && refill_evicts) begin
      victim_next = (victim_reg == LAST_IDX) ? '0 : victim_reg + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg  <= '0;
      victim_reg <= '0;
    end else begin
      victim_reg <= victim_next;
      if (io_flush) begin
        valid_reg <= '0;
      end else if (refill_fire) begin
        valid_reg[refill_slot] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (refill_fire) begin
      tag_mem[refill_slot]  <= io_refill_vpn;
      data_mem[refill_slot] <= io_refill_data;
    end
  end

  // Single-stage response register. A flush never cancels a registered
  // response; reset discards it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_reg <= 1'b0;
      resp_hit_reg   <= 1'b0;
      resp_data_reg  <= '0;
    end else if (req_fire) begin
      resp_valid_reg <= 1'b1;
      resp_hit_reg   <= lookup_hit;
      resp_data_reg  <= lookup_data;
    end else if (io_resp_ready) begin
      resp_valid_reg <= 1'b0;
    end
  end

`ifdef TLB_HIT_COUNT_EN
  logic [15:0] hit_count_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_count_reg <= '0;
    end else if (io_flush) begin
      hit_count_reg <= '0;
    end else if (req_fire && lookup_hit && (hit_count_reg != 16'hFFFF)) begin
      hit_count_reg <= hit_count_reg + 16'd1;
    end
  end

  assign io_hit_count = hit_count_reg;
`endif

  assign io_resp_valid = resp_valid_reg;
  assign io_resp_hit   = resp_hit_reg;
  assign io_resp_ppn   = resp_data_reg[31:12];
  assign io_resp_u     = resp_data_reg[11];
  assign io_resp_ae    = resp_data_reg[10];
  assign io_resp_sw    = resp_data_reg[9];
  assign io_resp_sx    = resp_data_reg[8];
  assign io_resp_sr    = resp_data_reg[7];
  assign io_resp_pw    = resp_data_reg[6];
  assign io_resp_px    = resp_data_reg[5];
  assign io_resp_pr    = resp_data_reg[4];
  assign io_resp_pal   = resp_data_reg[3];
  assign io_resp_paa   = resp_data_reg[2];
  assign io_resp_eff   = resp_data_reg[1];
  assign io_resp_c     = resp_data_reg[0];

endmodule

// File: tb/tb_tlb_entry_reader.sv
`timescale 1ns/1ps

module tb_tlb_entry_reader;

  localparam int VPN_BITS = 27;

  logic                clock;
  logic                reset_n;
  logic                io_refill_valid;
  logic [VPN_BITS-1:0] io_refill_vpn;
  logic [31:0]         io_refill_data;
  logic                io_flush;
  logic                io_req_valid;
  logic                io_req_ready;
  logic [VPN_BITS-1:0] io_req_vpn;
  logic                io_resp_valid;
  logic                io_resp_ready;
  logic                io_resp_hit;
  logic [19:0]         io_resp_ppn;
  logic io_resp_u, io_resp_ae, io_resp_sw, io_resp_sx, io_resp_sr, io_resp_pw;
  logic io_resp_px, io_resp_pr, io_resp_pal, io_resp_paa, io_resp_eff, io_resp_c;
`ifdef TLB_HIT_COUNT_EN
  logic [15:0]         io_hit_count;
`endif

  tlb_entry_reader #(.ENTRIES(8), .VPN_BITS(VPN_BITS)) dut (
    .clock(clock), .reset_n(reset_n),
    .io_refill_valid(io_refill_valid), .io_refill_vpn(io_refill_vpn),
    .io_refill_data(io_refill_data), .io_flush(io_flush),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready), .io_req_vpn(io_req_vpn),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_hit(io_resp_hit), .io_resp_ppn(io_resp_ppn),
    .io_resp_u(io_resp_u), .io_resp_ae(io_resp_ae), .io_resp_sw(io_resp_sw),
    .io_resp_sx(io_resp_sx), .io_resp_sr(io_resp_sr), .io_resp_pw(io_resp_pw),
    .io_resp_px(io_resp_px), .io_resp_pr(io_resp_pr), .io_resp_pal(io_resp_pal),
    .io_resp_paa(io_resp_paa), .io_resp_eff(io_resp_eff),
`ifdef TLB_HIT_COUNT_EN
    .io_hit_count(io_hit_count),
`endif
    .io_resp_c(io_resp_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        hit;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  wire [31:0] resp_packed = {io_resp_ppn, io_resp_u, io_resp_ae, io_resp_sw, io_resp_sx,
                             io_resp_sr, io_resp_pw, io_resp_px, io_resp_pr, io_resp_pal,
                             io_resp_paa, io_resp_eff, io_resp_c};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clock) begin
    if (reset_n && io_resp_valid && io_resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL resp_unexpected: got response hit=%0b data=0x%08h with empty scoreboard",
                 io_resp_hit, resp_packed);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_hit", 64'(io_resp_hit), 64'(e.hit));
        chk("resp_fields", 64'(resp_packed), 64'(e.data));
      end
    end
  end

  // Inputs change 1ns after the rising edge; tasks start and end there.
  task automatic refill(input logic [VPN_BITS-1:0] vpn, input logic [31:0] data);
    io_refill_valid = 1'b1;
    io_refill_vpn   = vpn;
    io_refill_data  = data;
    @(posedge clock); #1;
    io_refill_valid = 1'b0;
  endtask

  task automatic flush();
    io_flush = 1'b1;
    @(posedge clock); #1;
    io_flush = 1'b0;
  endtask

  task automatic lookup(input logic [VPN_BITS-1:0] vpn, input logic hit,
                        input logic [31:0] data, input bit push);
    int n;
    exp_t e;
    e.hit  = hit;
    e.data = hit ? data : 32'h0;
    if (push) exp_q.push_back(e);
    io_req_valid = 1'b1;
    io_req_vpn   = vpn;
    n = 0;
    @(negedge clock);
    while (!io_req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!io_req_ready) begin
      checks++;
      fails++;
      $display("FAIL req_timeout: got io_req_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clock); #1;
    io_req_valid = 1'b0;
    chk("resp_latency1", 64'(io_resp_valid), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0;
    io_refill_valid = 1'b0; io_refill_vpn = '0; io_refill_data = '0;
    io_flush = 1'b0; io_req_valid = 1'b0; io_req_vpn = '0; io_resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_req_ready", 64'(io_req_ready), 64'd1);
    chk("reset_resp_valid", 64'(io_resp_valid), 64'd0);
    chk("reset_resp_hit", 64'(io_resp_hit), 64'd0);
    chk("reset_resp_fields", 64'(resp_packed), 64'd0);
`ifdef TLB_HIT_COUNT_EN
    chk("reset_hit_count", 64'(io_hit_count), 64'd0);
`endif
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Basic hit with field unpacking, then a miss.
    refill(27'h12345, 32'hABCDE5A5);
    lookup(27'h12345, 1'b1, 32'hABCDE5A5, 1'b1);
`ifdef TLB_HIT_COUNT_EN
    chk("hit_count_one", 64'(io_hit_count), 64'd1);
`endif
    lookup(27'h7, 1'b0, 32'h0, 1'b1);

    // Same-cycle refill and lookup reads the old contents.
    io_refill_valid = 1'b1; io_refill_vpn = 27'h999; io_refill_data = 32'h13579F0F;
    lookup(27'h999, 1'b0, 32'h0, 1'b1);
    io_refill_valid = 1'b0;
    lookup(27'h999, 1'b1, 32'h13579F0F, 1'b1);

    // Replacement: fill 8, 9th evicts entry 0, 10th evicts entry 1.
    flush();
    for (int i = 0; i < 9; i++) refill(27'h100 + 27'(i), {20'h00100 + 20'(i), 12'h0F0});
    lookup(27'h100, 1'b0, 32'h0, 1'b1);
    lookup(27'h108, 1'b1, {20'h00108, 12'h0F0}, 1'b1);
    lookup(27'h107, 1'b1, {20'h00107, 12'h0F0}, 1'b1);
    refill(27'h109, 32'h00109AAA);
    lookup(27'h101, 1'b0, 32'h0, 1'b1);
    lookup(27'h102, 1'b1, {20'h00102, 12'h0F0}, 1'b1);
    // Rewriting a present tag updates in place and does not move the victim.
    refill(27'h102, 32'h77777555);
    lookup(27'h102, 1'b1, 32'h77777555, 1'b1);
    refill(27'h10A, 32'h0010A001);
    lookup(27'h102, 1'b0, 32'h0, 1'b1);
    lookup(27'h103, 1'b1, {20'h00103, 12'h0F0}, 1'b1);

    // Backpressure: response held for 3 cycles, then released with a new request.
    refill(27'h12345, 32'hABCDE5A5);
    io_resp_ready = 1'b0;
    lookup(27'h12345, 1'b1, 32'hABCDE5A5, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("stall_req_ready", 64'(io_req_ready), 64'd0);
      chk("stall_resp_valid", 64'(io_resp_valid), 64'd1);
      chk("stall_resp_fields", 64'(resp_packed), 64'hABCDE5A5);
      @(posedge clock); #1;
    end
    io_resp_ready = 1'b1;
    lookup(27'h7, 1'b0, 32'h0, 1'b1);

    // Flush and refill together: the refill is dropped.
    io_refill_valid = 1'b1; io_refill_vpn = 27'h55; io_refill_data = 32'h55555FFF;
    flush();
    io_refill_valid = 1'b0;
    lookup(27'h55, 1'b0, 32'h0, 1'b1);
`ifdef TLB_HIT_COUNT_EN
    chk("hit_count_flushed", 64'(io_hit_count), 64'd0);
`endif

    // Reset mid-transaction discards the pending response.
    refill(27'h66, 32'h66666001);
    io_resp_ready = 1'b0;
    lookup(27'h66, 1'b1, 32'h66666001, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk("midreset_resp_valid", 64'(io_resp_valid), 64'd0);
    chk("midreset_req_ready", 64'(io_req_ready), 64'd1);
    @(negedge clock);
    reset_n = 1'b1;
    io_resp_ready = 1'b1;
    @(posedge clock); #1;
    chk("postreset_resp_valid", 64'(io_resp_valid), 64'd0);
    lookup(27'h66, 1'b0, 32'h0, 1'b1);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clock);
      n++;
    end
    @(posedge clock); #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
